// File: rtl/xillybus_loopback_pkg.sv
// Shared types and constants for the Xillybus user loopback block:
// stream FSM encoding, register-space addresses and the ID word.
package xillybus_loopback_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_AW    = 5;
  localparam int unsigned SCRATCH_N = 16;

  localparam logic [DATA_W-1:0] ID_VALUE = 32'h584C_4C42;

  // Register-space addresses
  localparam logic [MEM_AW-1:0] REG_ID       = 5'd0;
  localparam logic [MEM_AW-1:0] REG_COUNT    = 5'd1;
  localparam logic [MEM_AW-1:0] REG_OVF      = 5'd2;
  localparam logic [MEM_AW-1:0] REG_UNF      = 5'd3;
  localparam logic [MEM_AW-1:0] REG_STATE    = 5'd4;
  localparam logic [MEM_AW-1:0] SCRATCH_BASE = 5'd16;

  // Stream FSM; the raw encoding is visible through the state register.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_EOF    = 3'd3
  } stream_state_e;

  // Increment that sticks at all-ones.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/xillybus_user_loopback_if.sv
// Host-side bundle of the Xillybus loopback: the 32-bit stream pair, the
// 32-bit register-space pair with its address, and the core quiesce flag.
// master = core/host side (drives strobes), slave = user logic.
interface xillybus_user_loopback_if;
  import xillybus_loopback_pkg::*;

  logic                quiesce;

  logic                user_w_write_32_wren;
  logic [DATA_W-1:0]   user_w_write_32_data;
  logic                user_w_write_32_open;
  logic                user_w_write_32_full;

  logic                user_r_read_32_rden;
  logic                user_r_read_32_open;
  logic [DATA_W-1:0]   user_r_read_32_data;
  logic                user_r_read_32_empty;
  logic                user_r_read_32_eof;

  logic                user_w_mem_32_wren;
  logic [DATA_W-1:0]   user_w_mem_32_data;
  logic                user_w_mem_32_open;
  logic                user_w_mem_32_full;

  logic                user_r_mem_32_rden;
  logic                user_r_mem_32_open;
  logic [DATA_W-1:0]   user_r_mem_32_data;
  logic                user_r_mem_32_empty;
  logic                user_r_mem_32_eof;

  logic [MEM_AW-1:0]   user_mem_32_addr;
  logic                user_mem_32_addr_update;

  modport master (
    output quiesce,
    output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    input  user_w_write_32_full,
    output user_r_read_32_rden, user_r_read_32_open,
    input  user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
    output user_w_mem_32_wren, user_w_mem_32_data, user_w_mem_32_open,
    input  user_w_mem_32_full,
    output user_r_mem_32_rden, user_r_mem_32_open,
    input  user_r_mem_32_data, user_r_mem_32_empty, user_r_mem_32_eof,
    output user_mem_32_addr, user_mem_32_addr_update
  );

  modport slave (
    input  quiesce,
    input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    output user_w_write_32_full,
    input  user_r_read_32_rden, user_r_read_32_open,
    output user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
    input  user_w_mem_32_wren, user_w_mem_32_data, user_w_mem_32_open,
    output user_w_mem_32_full,
    input  user_r_mem_32_rden, user_r_mem_32_open,
    output user_r_mem_32_data, user_r_mem_32_empty, user_r_mem_32_eof,
    input  user_mem_32_addr, user_mem_32_addr_update
  );

endinterface

// File: rtl/xillybus_sync_fifo.sv
// Single-clock FIFO, 2^AW words, non-FWFT read port.
// Ports: clk/rst (sync active-high); wr_en/wr_data push when not full;
// rd_en pops when not empty, rd_data holds the popped word until the next pop;
// flush clears pointers and count; count/full_c/empty_c report occupancy.
module xillybus_sync_fifo #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_c;
  logic          pop_c;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign push_c  = wr_en && !full_c;
  assign pop_c   = rd_en && !empty_c;

  // Storage: no reset, contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/xillybus_user_loopback.sv
// Xillybus user-side loopback: host writes on the 32-bit write stream come
// back on the 32-bit read stream through a FIFO, with an EOF handshake once
// the writer closes and the data drains. The register space exposes an ID,
// FIFO occupancy, overflow/underflow counters, the FSM state and scratch RAM.
// Ports: bus_clk, bus_reset (sync active-high); bus = Xillybus slave bundle.
module xillybus_user_loopback
  import xillybus_loopback_pkg::*;
#(
  parameter int unsigned FIFO_AW = 9
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset,
  xillybus_user_loopback_if.slave  bus
);

  localparam int unsigned CW = FIFO_AW + 1;

  stream_state_e     state;
  stream_state_e     state_nxt;
  logic [CW-1:0]     count;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              eof_c;
  logic              empty_c;
  logic              flush_c;
  logic              wr_drop_c;
  logic              rd_miss_c;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [DATA_W-1:0] ovf_cnt;
  logic [DATA_W-1:0] unf_cnt;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] reg_rd_c;
  logic [DATA_W-1:0] scratch [SCRATCH_N];
  logic              scratch_we_c;
  logic              ovf_clr_c;
  logic              unf_clr_c;
  logic              unused_c;

  assign eof_c   = (state == ST_EOF);
  // EOF always reads as empty so the host never pops past end-of-file.
  assign empty_c = fifo_empty_c || eof_c;

  // Both files closed (outside a drain) or core quiescent: drop FIFO contents.
  assign flush_c = bus.quiesce ||
                   (!bus.user_w_write_32_open && !bus.user_r_read_32_open &&
                    (state != ST_DRAIN));

  assign wr_drop_c = bus.user_w_write_32_wren && fifo_full_c;
  assign rd_miss_c = bus.user_r_read_32_rden && empty_c;

  assign scratch_we_c = bus.user_w_mem_32_wren && bus.user_mem_32_addr[4];
  assign ovf_clr_c    = bus.user_w_mem_32_wren && (bus.user_mem_32_addr == REG_OVF);
  assign unf_clr_c    = bus.user_w_mem_32_wren && (bus.user_mem_32_addr == REG_UNF);

  // The register space has no use for its open flags.
  assign unused_c = &{1'b0, bus.user_w_mem_32_open, bus.user_r_mem_32_open};

  xillybus_sync_fifo #(
    .AW (FIFO_AW),
    .DW (DATA_W)
  ) u_fifo (
    .clk     (bus_clk),
    .rst     (bus_reset),
    .wr_en   (bus.user_w_write_32_wren),
    .wr_data (bus.user_w_write_32_data),
    .rd_en   (bus.user_r_read_32_rden && !eof_c),
    .flush   (flush_c),
    .rd_data (fifo_rd_data),
    .count   (count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Stream FSM state register.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stream FSM next state: flush first, then a reopen wins from anywhere.
  always_comb begin
    state_nxt = state;
    if (flush_c) begin
      state_nxt = ST_IDLE;
    end else if (bus.user_w_write_32_open) begin
      state_nxt = ST_STREAM;
    end else begin
      case (state)
        ST_STREAM: state_nxt = (count == '0) ? ST_EOF : ST_DRAIN;
        ST_DRAIN:  if (count == '0) state_nxt = ST_EOF;
        ST_EOF:    if (!bus.user_r_read_32_open) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Overflow/underflow counters; a register write clears and beats an increment.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (ovf_clr_c) begin
        ovf_cnt <= '0;
      end else if (wr_drop_c) begin
        ovf_cnt <= sat_inc(ovf_cnt);
      end
      if (unf_clr_c) begin
        unf_cnt <= '0;
      end else if (rd_miss_c) begin
        unf_cnt <= sat_inc(unf_cnt);
      end
    end
  end

  // Scratch RAM in the upper half of the register space.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      for (int i = 0; i < SCRATCH_N; i++) begin
        scratch[i] <= '0;
      end
    end else if (scratch_we_c) begin
      scratch[bus.user_mem_32_addr[3:0]] <= bus.user_w_mem_32_data;
    end
  end

  // Register read mux.
  always_comb begin
    reg_rd_c = '0;
    case (bus.user_mem_32_addr)
      REG_ID:    reg_rd_c = ID_VALUE;
      REG_COUNT: reg_rd_c = DATA_W'(count);
      REG_OVF:   reg_rd_c = ovf_cnt;
      REG_UNF:   reg_rd_c = unf_cnt;
      REG_STATE: reg_rd_c = DATA_W'(state);
      default: begin
        if (bus.user_mem_32_addr[4]) begin
          reg_rd_c = scratch[bus.user_mem_32_addr[3:0]];
        end
      end
    endcase
  end

  // Register read data; captured before any same-cycle write lands.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      mem_rd_data <= '0;
    end else if (bus.user_r_mem_32_rden || bus.user_mem_32_addr_update) begin
      mem_rd_data <= reg_rd_c;
    end
  end

  assign bus.user_w_write_32_full = fifo_full_c;
  assign bus.user_r_read_32_data  = fifo_rd_data;
  assign bus.user_r_read_32_empty = empty_c;
  assign bus.user_r_read_32_eof   = eof_c;
  assign bus.user_w_mem_32_full   = 1'b0;
  assign bus.user_r_mem_32_data   = mem_rd_data;
  assign bus.user_r_mem_32_empty  = 1'b0;
  assign bus.user_r_mem_32_eof    = 1'b0;

endmodule

// File: tb/tb_xillybus_user_loopback.sv
// Self-checking bench for xillybus_user_loopback: register-map vector table,
// stream traffic against a scoreboard queue, and hand-written EOF, overflow,
// underflow, quiesce and reset sequences.
module tb_xillybus_user_loopback;
  import xillybus_loopback_pkg::*;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          NVEC  = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] sb[$];
  logic [31:0] m_last_rd;
  logic [31:0] m_ovf;
  logic [31:0] m_unf;
  logic [31:0] rv;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[NVEC];

  xillybus_user_loopback_if bus();

  xillybus_user_loopback #(.FIFO_AW(AW)) dut (
    .bus_clk   (clk),
    .bus_reset (rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic reg_read(input logic [4:0] a, output logic [31:0] v);
    bus.user_mem_32_addr   = a;
    bus.user_r_mem_32_rden = 1'b1;
    step();
    bus.user_r_mem_32_rden = 1'b0;
    v = bus.user_r_mem_32_data;
  endtask

  task automatic reg_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(a, v);
    check(name, v, exp);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    bus.user_mem_32_addr   = a;
    bus.user_w_mem_32_data = d;
    bus.user_w_mem_32_wren = 1'b1;
    step();
    bus.user_w_mem_32_wren = 1'b0;
  endtask

  // One stream cycle; the scoreboard predicts acceptance, pop data and flags.
  task automatic cycle(input logic wr, input logic [31:0] wd, input logic rd);
    logic acc;
    logic pop;
    acc = wr && (sb.size() < DEPTH);
    pop = rd && (sb.size() != 0);
    bus.user_w_write_32_wren = wr;
    bus.user_w_write_32_data = wd;
    bus.user_r_read_32_rden  = rd;
    step();
    bus.user_w_write_32_wren = 1'b0;
    bus.user_r_read_32_rden  = 1'b0;
    if (pop) m_last_rd = sb.pop_front();
    if (acc) sb.push_back(wd);
    if (wr && !acc) m_ovf = sat(m_ovf);
    if (rd && !pop) m_unf = sat(m_unf);
    check("read_32_data", bus.user_r_read_32_data, m_last_rd);
    check("full", {31'b0, bus.user_w_write_32_full}, {31'b0, sb.size() == DEPTH});
    check("empty", {31'b0, bus.user_r_read_32_empty}, {31'b0, sb.size() == 0});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,          32'h584C_4C42};
    vecs[1]  = '{1'b1, 5'd0,  32'h1234_5678,  32'h584C_4C42};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,          32'h584C_4C42};
    vecs[3]  = '{1'b1, 5'd20, 32'hDEAD_BEEF,  32'h0};
    vecs[4]  = '{1'b0, 5'd20, 32'h0,          32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 5'd31, 32'hA5A5_0001,  32'h0};
    vecs[6]  = '{1'b0, 5'd31, 32'h0,          32'hA5A5_0001};
    vecs[7]  = '{1'b1, 5'd5,  32'hFFFF_FFFF,  32'h0};
    vecs[8]  = '{1'b0, 5'd5,  32'h0,          32'h0};
    vecs[9]  = '{1'b0, 5'd15, 32'h0,          32'h0};
    vecs[10] = '{1'b0, 5'd4,  32'h0,          32'h0};
    vecs[11] = '{1'b0, 5'd1,  32'h0,          32'h0};
    vecs[12] = '{1'b1, 5'd16, 32'h0BAD_F00D,  32'h0};
    vecs[13] = '{1'b0, 5'd16, 32'h0,          32'h0BAD_F00D};
    vecs[14] = '{1'b0, 5'd20, 32'h0,          32'hDEAD_BEEF};

    rst = 1'b1;
    bus.quiesce                 = 1'b0;
    bus.user_w_write_32_wren    = 1'b0;
    bus.user_w_write_32_data    = '0;
    bus.user_w_write_32_open    = 1'b0;
    bus.user_r_read_32_rden     = 1'b0;
    bus.user_r_read_32_open     = 1'b0;
    bus.user_w_mem_32_wren      = 1'b0;
    bus.user_w_mem_32_data      = '0;
    bus.user_w_mem_32_open      = 1'b1;
    bus.user_r_mem_32_rden      = 1'b0;
    bus.user_r_mem_32_open      = 1'b1;
    bus.user_mem_32_addr        = '0;
    bus.user_mem_32_addr_update = 1'b0;
    m_last_rd = '0;
    m_ovf     = '0;
    m_unf     = '0;

    // Reset state
    step();
    step();
    check("rst_full",      {31'b0, bus.user_w_write_32_full}, 32'd0);
    check("rst_empty",     {31'b0, bus.user_r_read_32_empty}, 32'd1);
    check("rst_eof",       {31'b0, bus.user_r_read_32_eof},   32'd0);
    check("rst_rd_data",   bus.user_r_read_32_data,           32'd0);
    check("rst_mem_data",  bus.user_r_mem_32_data,            32'd0);
    check("tied_mem_full", {31'b0, bus.user_w_mem_32_full},   32'd0);
    check("tied_mem_empty",{31'b0, bus.user_r_mem_32_empty},  32'd0);
    check("tied_mem_eof",  {31'b0, bus.user_r_mem_32_eof},    32'd0);
    rst = 1'b0;
    step();

    // Register map: write and read the same address in one cycle, then read back
    for (int i = 0; i < NVEC; i++) begin
      bus.user_mem_32_addr   = vecs[i].addr;
      bus.user_w_mem_32_data = vecs[i].wdata;
      bus.user_w_mem_32_wren = vecs[i].wr;
      bus.user_r_mem_32_rden = 1'b1;
      step();
      bus.user_w_mem_32_wren = 1'b0;
      bus.user_r_mem_32_rden = 1'b0;
      check($sformatf("reg_vec%0d", i), bus.user_r_mem_32_data, vecs[i].exp);
    end

    // addr_update alone loads the read word; no strobe holds it
    bus.user_mem_32_addr        = 5'd20;
    bus.user_mem_32_addr_update = 1'b1;
    step();
    bus.user_mem_32_addr_update = 1'b0;
    check("addr_update", bus.user_r_mem_32_data, 32'hDEAD_BEEF);
    bus.user_mem_32_addr = 5'd31;
    step();
    check("mem_data_hold", bus.user_r_mem_32_data, 32'hDEAD_BEEF);

    // Open both streams; ordered loopback of 0x1..0x10
    bus.user_w_write_32_open = 1'b1;
    bus.user_r_read_32_open  = 1'b1;
    step();
    reg_check("state_stream", REG_STATE, 32'd1);
    for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0);
    reg_check("count16", REG_COUNT, 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1);

    // Random mixed traffic including underflows
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    reg_check("rand_count", REG_COUNT, 32'(sb.size()));
    reg_check("rand_ovf",   REG_OVF,   m_ovf);
    reg_check("rand_unf",   REG_UNF,   m_unf);

    reg_write(REG_OVF, 32'h0);
    reg_write(REG_UNF, 32'h0);
    m_ovf = '0;
    m_unf = '0;
    reg_check("ovf_cleared", REG_OVF, 32'd0);

    // Fill to full, then one dropped word
    while (sb.size() < DEPTH) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, 32'h0000_0513, 1'b0);
    reg_check("ovf_one",    REG_OVF,   32'd1);
    reg_check("count_full", REG_COUNT, 32'(DEPTH));
    reg_write(REG_OVF, 32'h0);
    m_ovf = '0;
    reg_check("ovf_clr_full", REG_OVF, 32'd0);

    // At full: pop happens, write dropped
    cycle(1'b1, 32'hBAD0_0001, 1'b1);
    reg_check("full_rw_count", REG_COUNT, 32'(DEPTH - 1));
    reg_check("full_rw_ovf",   REG_OVF,   32'd1);

    while (sb.size() != 0) cycle(1'b0, 32'h0, 1'b1);

    // At empty: write accepted, read is an underflow
    reg_write(REG_UNF, 32'h0);
    m_unf = '0;
    cycle(1'b1, 32'hCAFE_0001, 1'b1);
    reg_check("empty_rw_count", REG_COUNT, 32'd1);
    reg_check("empty_rw_unf",   REG_UNF,   32'd1);
    cycle(1'b0, 32'h0, 1'b1);

    // Counter clear wins over a same-cycle underflow
    bus.user_mem_32_addr     = REG_UNF;
    bus.user_w_mem_32_wren   = 1'b1;
    bus.user_r_read_32_rden  = 1'b1;
    step();
    bus.user_w_mem_32_wren   = 1'b0;
    bus.user_r_read_32_rden  = 1'b0;
    m_unf = '0;
    check("unf_hold_data", bus.user_r_read_32_data, m_last_rd);
    reg_check("unf_clear_wins", REG_UNF, 32'd0);

    // Drain then EOF handshake
    for (int i = 1; i <= 3; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
    bus.user_w_write_32_open = 1'b0;
    step();
    check("drain_eof", {31'b0, bus.user_r_read_32_eof}, 32'd0);
    reg_check("state_drain", REG_STATE, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    step();
    reg_check("state_eof", REG_STATE, 32'd3);
    check("eof_set",   {31'b0, bus.user_r_read_32_eof},   32'd1);
    check("eof_empty", {31'b0, bus.user_r_read_32_empty}, 32'd1);
    bus.user_r_read_32_open = 1'b0;
    step();
    check("eof_clear", {31'b0, bus.user_r_read_32_eof}, 32'd0);
    reg_check("state_idle", REG_STATE, 32'd0);

    // Quiesce flushes the FIFO but keeps the counters
    bus.user_w_write_32_open = 1'b1;
    bus.user_r_read_32_open  = 1'b1;
    step();
    cycle(1'b1, 32'h1111_0001, 1'b0);
    cycle(1'b1, 32'h1111_0002, 1'b0);
    bus.quiesce = 1'b1;
    step();
    sb.delete();
    check("quiesce_empty", {31'b0, bus.user_r_read_32_empty}, 32'd1);
    reg_check("quiesce_count", REG_COUNT, 32'd0);
    reg_check("quiesce_state", REG_STATE, 32'd0);
    reg_check("quiesce_ovf",   REG_OVF,   m_ovf);
    bus.quiesce = 1'b0;
    step();
    reg_check("reopen_state", REG_STATE, 32'd1);

    // Reset mid-stream with all strobes high
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h5000 + 32'(i), 1'b0);
    reg_write(5'd16, 32'h5555_AAAA);
    reg_check("pre_rst_count",   REG_COUNT, 32'd5);
    reg_check("pre_rst_scratch", 5'd16,     32'h5555_AAAA);
    rst = 1'b1;
    bus.user_w_write_32_wren = 1'b1;
    bus.user_r_read_32_rden  = 1'b1;
    bus.user_w_mem_32_wren   = 1'b1;
    bus.user_r_mem_32_rden   = 1'b1;
    bus.user_mem_32_addr     = 5'd17;
    step();
    check("mid_rst_full",     {31'b0, bus.user_w_write_32_full}, 32'd0);
    check("mid_rst_empty",    {31'b0, bus.user_r_read_32_empty}, 32'd1);
    check("mid_rst_eof",      {31'b0, bus.user_r_read_32_eof},   32'd0);
    check("mid_rst_rd_data",  bus.user_r_read_32_data,           32'd0);
    check("mid_rst_mem_data", bus.user_r_mem_32_data,            32'd0);
    rst = 1'b0;
    bus.user_w_write_32_wren = 1'b0;
    bus.user_r_read_32_rden  = 1'b0;
    bus.user_w_mem_32_wren   = 1'b0;
    bus.user_r_mem_32_rden   = 1'b0;
    sb.delete();
    m_last_rd = '0;
    m_ovf     = '0;
    m_unf     = '0;
    reg_check("post_rst_count",   REG_COUNT, 32'd0);
    reg_check("post_rst_scratch", 5'd16,     32'd0);
    reg_check("post_rst_ovf",     REG_OVF,   32'd0);
    cycle(1'b1, 32'h0000_0077, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xillybus_user_loopback.md
XILLYBUS_USER_LOOPBACK -- requirements
Module: xillybus_user_loopback

Interface
REQ-001 Parameter: FIFO_AW, default 9, log2 of the loopback FIFO depth (depth 512 words).
REQ-002 The clock is bus_clk and the reset is bus_reset; there is one clock, and reset is synchronous and active-high.
REQ-003 bus_clk  in  1  sole clock, all logic rising-edge.
REQ-004 bus_reset  in  1  synchronous active-high reset.
REQ-005 quiesce  in  1  core quiescent; treated as both streams closed.
REQ-006 user_w_write_32_wren / _data / _open  in  1/32/1  host-to-FPGA stream write strobe, word, file open.
REQ-007 user_w_write_32_full  out  1  FIFO cannot accept a word this cycle.
REQ-008 user_r_read_32_rden / _open  in  1/1  FPGA-to-host stream read strobe, file open.
REQ-009 user_r_read_32_data / _empty / _eof  out  32/1/1  read word, FIFO empty, end-of-file.
REQ-010 user_w_mem_32_wren / _data / _open  in  1/32/1  register-space write strobe, word, open.
REQ-011 user_r_mem_32_rden / _open  in  1/1  register-space read strobe, open.
REQ-012 user_mem_32_addr / _addr_update  in  5/1  register address, address-changed strobe.
REQ-013 user_r_mem_32_data  out  32  register read word; user_r_mem_32_empty, _eof, user_w_mem_32_full  out  1  tied 0.

Function
REQ-014 A write is accepted iff wren=1 and full=0; accepted data is stored at the tail of the FIFO, and count increments.
REQ-015 If wren=1 while full=1, the word is dropped and ovf_cnt increments (saturating at 0xFFFFFFFF).
REQ-016 Reads are non-FWFT: rden=1 with empty=0 pops the head, and read_32_data holds that word from the next cycle until the next pop.
REQ-017 If rden=1 while empty=1, read_32_data is unchanged and unf_cnt increments (saturating).
REQ-018 When both an accepted write and a pop occur in the same cycle, count is unchanged. At empty, the write is accepted and the read is an underflow. At full, the pop is performed and the write is dropped (overflow).
REQ-019 full = (count == 2^FIFO_AW) and empty = (count == 0), both combinational from registered count; pointers wrap modulo 2^FIFO_AW.
REQ-020 Stream FSM states:
  - IDLE: write_open=0.
  - STREAM: IDLE->STREAM on write_open=1.
  - DRAIN: STREAM->DRAIN on write_open=0 with count>0.
  - EOF: STREAM->EOF on write_open=0 with count=0; DRAIN->EOF when count reaches 0.
REQ-021 From any state, write_open=1 returns the FSM to STREAM.
REQ-022 EOF->IDLE when read_open=0.
REQ-023 eof=1 only in EOF; empty is 1 whenever eof is 1.
REQ-024 Flush: when write_open=0, read_open=0 and FSM is not DRAIN, or when quiesce=1, pointers and count clear in one cycle, the FSM goes to IDLE, and counters are kept.
REQ-025 Register map, read port: reg[user_mem_32_addr] is registered into user_r_mem_32_data on a cycle with rden=1 or addr_update=1 (1-cycle latency).
  - 0: ID 0x584C4C42, read-only.
  - 1: count, zero-extended.
  - 2: ovf_cnt.
  - 3: unf_cnt.
  - 4: {29'b0, state[2:0]}.
  - 5-15: read 0.
  - 16-31: scratch, read/write.
REQ-026 Register map, write port: on user_w_mem_32_wren=1, scratch addresses store data. Any write to address 2 or 3 clears that counter, and the clear wins over a same-cycle increment. Writes to other addresses are ignored.
REQ-027 A same-cycle mem write and mem read of the same scratch address returns the old value.

Reset
REQ-028 During bus_reset: pointers and count are 0, FSM is IDLE, ovf_cnt/unf_cnt are 0, scratch is 0, and both data outputs are 0.
REQ-029 Reset values of outputs: full=0, empty=1, eof=0.
REQ-030 Reset overrides all strobes.
REQ-031 Reset mid-stream discards FIFO contents.

Structure
REQ-032 Package xillybus_loopback_pkg holds:
  - FSM state enum (IDLE=0, STREAM=1, DRAIN=2, EOF=3).
  - Register address constants and ID constant.
  - Scratch base 16.
REQ-033 Sub-module xillybus_sync_fifo holds the single-clock FIFO (storage, pointers, count), sized by FIFO_AW. The top holds the FSM, counters and register file.

Verification
REQ-034 Open both streams; write 0x1..0x10; read 16 words -> data 0x1..0x10 in order, one cycle after each rden; empty=1 after the last pop.
REQ-035 FIFO_AW=9: write 513 words -> full=1 after 512; reg 2 reads 1; write to reg 2, then read -> 0.
REQ-036 Write 3 words, drop write_open -> state 2 (DRAIN), eof=0; pop 3 -> state 3, eof=1, empty=1; drop read_open -> state 0, eof=0.
REQ-037 At count=512, wren+rden same cycle -> count 511, ovf_cnt=1. At count=0, wren+rden -> count 1, unf_cnt=1.
REQ-038 Write 0xDEADBEEF to addr 20; set addr=20 with addr_update -> data 0xDEADBEEF next cycle. Write to addr 0 -> reading addr 0 still returns 0x584C4C42.
REQ-039 Assert bus_reset with count=5 mid-stream -> next cycle count=0, empty=1, full=0, eof=0, scratch reads 0.
